alu_control_md: RTL and testbench

Parametrised ALU control unit with an integrated iterative multiply/divide sequencer and HI/LO registers. It sits in the decode/execute boundary of the MIPS datapath. It translates ALUop/FuncCode into the 4-bit ALU control code exactly as the single-cycle ALU control does, and adds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO handling. It drives a stall request to the pipeline while a multi-cycle operation blocks a dependent instruction.

---
 rtl/alu_control_md_if.sv | 30 +++
 rtl/alu_control_md.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_control_md.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_md_if.sv
// Bundle of decode inputs and control/result outputs for alu_control_md.
// The master side (pipeline/testbench) drives the instruction fields and
// operands; the slave side (the control unit) drives decode and MD results.
interface alu_control_md_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       ALUop;
    logic [5:0]       FuncCode;
    logic             Valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUCtrl;
    logic             Illegal;
    logic             MfSel;
    logic [WIDTH-1:0] MfResult;
    logic             Stall;
    logic             MDBusy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output ALUop, FuncCode, Valid, A, B,
        input  ALUCtrl, Illegal, MfSel, MfResult, Stall, MDBusy, HI, LO
    );

    modport slave (
        input  ALUop, FuncCode, Valid, A, B,
        output ALUCtrl, Illegal, MfSel, MfResult, Stall, MDBusy, HI, LO
    );
endinterface

// File: rtl/alu_control_md.sv
// ALU control decode with an iterative multiply/divide sequencer and the
// architectural HI/LO registers. ALU decode is purely combinational; MULT/DIV
// run one shift-add or restoring-subtract step per cycle, then a single fix-up
// cycle applies signs and writes HI/LO.
module alu_control_md #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] PASS_OP = 4'b1111
) (
    input logic              CLK,
    input logic              Reset_L,
    alu_control_md_if.slave  bus
);
    // ALU control codes understood by the downstream ALU
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_ADDU = 4'b1000;
    localparam logic [3:0] ALU_SUBU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // R-type funct encodings
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    // acc_hi: partial product high half / running remainder
    // acc_lo: multiplier being consumed / dividend shifting into quotient
    logic [WIDTH-1:0] acc_hi_reg, acc_hi_next;
    logic [WIDTH-1:0] acc_lo_reg, acc_lo_next;
    logic [WIDTH-1:0] opnd_reg, opnd_next;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             is_div_reg, is_div_next;
    logic             neg_lo_reg, neg_lo_next;  // negate product / quotient
    logic             neg_hi_reg, neg_hi_next;  // negate remainder
    logic             div_zero_reg, div_zero_next;

    logic [3:0] alu_code;
    logic       funct_illegal;
    logic       funct_md;
    logic       pass_sel;
    logic       active;
    logic       busy;
    logic       go;
    logic       op_signed;
    logic       op_start;
    logic       op_div;
    logic       a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_adj;

    // Funct field to ALU code; MD and unknown functs fall back to ADDU
    always_comb begin
        alu_code      = ALU_ADDU;
        funct_illegal = 1'b0;
        funct_md      = 1'b0;
        case (bus.FuncCode)
            F_SLL:  alu_code = ALU_SLL;
            F_SRL:  alu_code = ALU_SRL;
            F_SRA:  alu_code = ALU_SRA;
            F_ADD:  alu_code = ALU_ADD;
            F_ADDU: alu_code = ALU_ADDU;
            F_SUB:  alu_code = ALU_SUB;
            F_SUBU: alu_code = ALU_SUBU;
            F_AND:  alu_code = ALU_AND;
            F_OR:   alu_code = ALU_OR;
            F_XOR:  alu_code = ALU_XOR;
            F_NOR:  alu_code = ALU_NOR;
            F_SLT:  alu_code = ALU_SLT;
            F_SLTU: alu_code = ALU_SLTU;
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: funct_md = 1'b1;
            default: funct_illegal = 1'b1;
        endcase
    end

    assign pass_sel = (bus.ALUop == PASS_OP);
    assign active   = bus.Valid && pass_sel && funct_md;
    assign busy     = (state_reg != ST_IDLE);
    // Every MD instruction waits while the sequencer is occupied
    assign go       = active && !busy;

    assign op_start  = (bus.FuncCode == F_MULT) || (bus.FuncCode == F_MULTU) ||
                       (bus.FuncCode == F_DIV)  || (bus.FuncCode == F_DIVU);
    assign op_div    = (bus.FuncCode == F_DIV)  || (bus.FuncCode == F_DIVU);
    assign op_signed = (bus.FuncCode == F_MULT) || (bus.FuncCode == F_DIV);
    assign a_neg     = op_signed && bus.A[WIDTH-1];
    assign b_neg     = op_signed && bus.B[WIDTH-1];
    assign a_mag     = a_neg ? (~bus.A + 1'b1) : bus.A;
    assign b_mag     = b_neg ? (~bus.B + 1'b1) : bus.B;

    // One shift-add step: add multiplicand when the current multiplier bit is set
    assign mult_sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);

    // One restoring step: a set top bit means the shifted remainder already
    // exceeds any W-bit divisor, and the true difference always fits in W bits
    assign div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    assign div_ge    = div_shift[WIDTH] || (div_shift[WIDTH-1:0] >= opnd_reg);
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_reg;

    assign prod      = {acc_hi_reg, acc_lo_reg};
    assign prod_adj  = neg_lo_reg ? (~prod + 1'b1) : prod;

    // Sequencer next state, datapath step and HI/LO write selection
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_hi_next   = acc_hi_reg;
        acc_lo_next   = acc_lo_reg;
        opnd_next     = opnd_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        is_div_next   = is_div_reg;
        neg_lo_next   = neg_lo_reg;
        neg_hi_next   = neg_hi_reg;
        div_zero_next = div_zero_reg;
        case (state_reg)
            ST_IDLE: begin
                if (go && bus.FuncCode == F_MTHI) hi_next = bus.A;
                if (go && bus.FuncCode == F_MTLO) lo_next = bus.A;
                if (go && op_start) begin
                    state_next    = ST_RUN;
                    cnt_next      = '0;
                    is_div_next   = op_div;
                    neg_lo_next   = a_neg ^ b_neg;
                    acc_hi_next   = '0;
                    if (op_div) begin
                        acc_lo_next   = a_mag;
                        opnd_next     = b_mag;
                        neg_hi_next   = a_neg;
                        div_zero_next = (bus.B == '0);
                    end else begin
                        acc_lo_next   = b_mag;
                        opnd_next     = a_mag;
                        neg_hi_next   = 1'b0;
                        div_zero_next = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (is_div_reg) begin
                    acc_hi_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    acc_lo_next = {acc_lo_reg[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_next = mult_sum[WIDTH:1];
                    acc_lo_next = {mult_sum[0], acc_lo_reg[WIDTH-1:1]};
                end
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_FIX;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            ST_FIX: begin
                if (is_div_reg) begin
                    lo_next = div_zero_reg ? '1 :
                              (neg_lo_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg);
                    hi_next = neg_hi_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
                end else begin
                    {hi_next, lo_next} = prod_adj;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            opnd_reg     <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            is_div_reg   <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_hi_reg   <= acc_hi_next;
            acc_lo_reg   <= acc_lo_next;
            opnd_reg     <= opnd_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            is_div_reg   <= is_div_next;
            neg_lo_reg   <= neg_lo_next;
            neg_hi_reg   <= neg_hi_next;
            div_zero_reg <= div_zero_next;
        end
    end

    assign bus.ALUCtrl  = pass_sel ? alu_code : bus.ALUop;
    assign bus.Illegal  = pass_sel && funct_illegal;
    assign bus.MfSel    = pass_sel && ((bus.FuncCode == F_MFHI) || (bus.FuncCode == F_MFLO));
    assign bus.MfResult = (bus.FuncCode == F_MFHI) ? hi_reg : lo_reg;
    assign bus.Stall    = active && busy;
    assign bus.MDBusy   = busy;
    assign bus.HI       = hi_reg;
    assign bus.LO       = lo_reg;
endmodule

// File: tb/tb_alu_control_md.sv
// Scoreboard bench for alu_control_md: MD results are predicted when an
// operation is issued and compared when MDBusy falls.
module tb_alu_control_md;
    localparam int         W    = 32;
    localparam logic [3:0] PASS = 4'b1111;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic CLK = 1'b0;
    logic Reset_L;
    always #5 CLK = ~CLK;

    alu_control_md_if #(.WIDTH(W)) bus ();

    alu_control_md #(.WIDTH(W), .PASS_OP(PASS)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    // Reference result {HI, LO} for a multiply/divide
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        r  = '0;
        case (f)
            F_MULT:  r = sa * sb;
            F_MULTU: r = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit expect_res);
        @(negedge CLK);
        bus.ALUop = PASS; bus.FuncCode = f; bus.A = a; bus.B = b; bus.Valid = 1'b1;
        if (expect_res) sb_q.push_back(model(f, a, b));
        $display("issue funct=%b A=%h B=%h", f, a, b);
        @(posedge CLK); #1;
        bus.Valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.MDBusy && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (bus.MDBusy) check("idle_timeout", 64'(bus.MDBusy), 64'd0);
    endtask

    // Monitor: pop and compare whenever an operation completes
    initial begin
        bit busy_prev = 1'b0;
        int busy_cnt  = 0;
        logic [63:0] e;
        forever begin
            @(negedge CLK);
            if (!Reset_L) begin
                busy_prev = 1'b0;
                busy_cnt  = 0;
            end else begin
                if (bus.MDBusy) busy_cnt++;
                else if (busy_prev) begin
                    if (sb_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
                    else begin
                        e = sb_q.pop_front();
                        check("result_hilo", {bus.HI, bus.LO}, e);
                        $display("done HI=%h LO=%h exp=%h", bus.HI, bus.LO, e);
                    end
                    check("busy_len", 64'(busy_cnt), 64'(W + 1));
                    busy_cnt = 0;
                end
                busy_prev = bus.MDBusy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] alu_f [13] = '{6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100001,
                                   6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                                   6'b100111, 6'b101010, 6'b101011};
        logic [3:0] alu_c [13] = '{4'b0011, 4'b0100, 4'b1101, 4'b0010, 4'b1000,
                                   4'b0110, 4'b1001, 4'b0000, 4'b0001, 4'b1010,
                                   4'b1100, 4'b0111, 4'b1011};
        logic [5:0] ops [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        int n;

        Reset_L = 1'b0;
        bus.ALUop = PASS; bus.FuncCode = F_MULT; bus.Valid = 1'b1;
        bus.A = 32'h1; bus.B = 32'h1;
        repeat (2) @(negedge CLK);
        check("rst_busy", 64'(bus.MDBusy), 64'd0);
        check("rst_stall", 64'(bus.Stall), 64'd0);
        check("rst_hilo", {bus.HI, bus.LO}, 64'd0);
        bus.Valid = 1'b0;
        @(posedge CLK); #2 Reset_L = 1'b1;

        // Decode sweep
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            bus.ALUop = PASS; bus.FuncCode = alu_f[i];
            #1;
            check("dec_alu", {59'd0, bus.Illegal, bus.ALUCtrl}, {59'd0, 1'b0, alu_c[i]});
            $display("decode funct=%b ctrl=%b", alu_f[i], bus.ALUCtrl);
        end
        bus.FuncCode = 6'b111111; #1;
        check("dec_illegal", {59'd0, bus.Illegal, bus.ALUCtrl}, {59'd0, 1'b1, 4'b1000});
        bus.FuncCode = F_MFLO; #1;
        check("dec_md", {58'd0, bus.MfSel, bus.Illegal, bus.ALUCtrl}, {58'd0, 1'b1, 1'b0, 4'b1000});
        bus.ALUop = 4'b0010; bus.FuncCode = F_MULT; bus.Valid = 1'b1; #1;
        check("dec_passthru", {59'd0, bus.Illegal, bus.ALUCtrl}, {59'd0, 1'b0, 4'b0010});
        bus.FuncCode = 6'b111111; #1;
        check("dec_pass_illegal", {59'd0, bus.Illegal, bus.ALUCtrl}, {59'd0, 1'b0, 4'b0010});
        @(posedge CLK); #1;
        check("nonpass_nostart", 64'(bus.MDBusy), 64'd0);
        // Valid=0 MD instruction must not start
        bus.ALUop = PASS; bus.FuncCode = F_MULT; bus.Valid = 1'b0;
        @(posedge CLK); #1;
        check("invalid_nostart", 64'(bus.MDBusy), 64'd0);

        // Directed MD operations
        issue(F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b1); wait_idle();
        issue(F_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1); wait_idle();
        issue(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1); wait_idle();
        issue(F_DIVU,  32'h0000_0007, 32'h0000_0000, 1'b1); wait_idle();
        issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
        issue(F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 1'b1); wait_idle();
        @(negedge CLK);
        check("mult_neg_const", model(F_MULT, 32'hFFFF_FFFE, 32'h3), 64'hFFFF_FFFF_FFFF_FFFA);

        // Hazard: MFLO held Valid behind a MULT
        issue(F_MULT, 32'd5, 32'd6, 1'b1);
        bus.FuncCode = F_MFLO; bus.Valid = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (!bus.Stall) break;
            n++;
        end
        check("mflo_stall_cycles", 64'(n), 64'(W + 1));
        check("mflo_sel", 64'(bus.MfSel), 64'd1);
        check("mflo_result", 64'(bus.MfResult), 64'd30);
        @(posedge CLK); #1 bus.Valid = 1'b0;
        wait_idle();

        // MTHI issued while busy waits, then lands after the result
        issue(F_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        bus.FuncCode = F_MTHI; bus.A = 32'hDEAD_BEEF; bus.Valid = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (!bus.Stall) break;
            n++;
        end
        check("mthi_stall_cycles", 64'(n), 64'(W + 1));
        @(posedge CLK); #1 bus.Valid = 1'b0;
        check("mthi_after", {bus.HI, bus.LO}, {32'hDEAD_BEEF, 32'hFFFF_FFFA});
        issue(F_MTLO, 32'h1234_5678, 32'h0, 1'b0);
        check("mtlo", 64'(bus.LO), 64'h1234_5678);
        bus.ALUop = PASS; bus.FuncCode = F_MFHI; #1;
        check("mfhi", {31'd0, bus.MfSel, bus.MfResult}, {31'd0, 1'b1, 32'hDEAD_BEEF});

        // Reset in the middle of RUN
        issue(F_MULT, 32'd7, 32'd9, 1'b0);
        repeat (9) @(posedge CLK);
        #2 Reset_L = 1'b0;
        #1;
        check("abort_busy", 64'(bus.MDBusy), 64'd0);
        check("abort_hilo", {bus.HI, bus.LO}, 64'd0);
        @(posedge CLK); #2 Reset_L = 1'b1;
        issue(F_MULT, 32'd3, 32'd4, 1'b1); wait_idle();

        // Random operations
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            issue(ops[$urandom_range(0, 3)], ra, rb, 1'b1);
            wait_idle();
        end

        @(negedge CLK);
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
